// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and constants for the VRAM port arbiter.
// Pixel address layout is {row[8:0], col[9:0]}.
package vram_port_arbiter_pkg;

  localparam int AW_DEF = 19;
  localparam int DW_DEF = 12;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_PEND = 2'd1;
  localparam logic [1:0] RD_DONE = 2'd2;

  typedef enum logic [1:0] {
    SLOT_VGA,
    SLOT_WR,
    SLOT_RD,
    SLOT_NONE
  } slot_e;

  function automatic logic [AW_DEF-1:0] pix_addr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// CPU-side bus of the VRAM arbiter: posted writes and
// single-outstanding reads.
interface vram_port_arbiter_if
  import vram_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          cpu_wr_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_ready;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic          cpu_rd_busy;
  logic          cpu_rd_valid;
  logic [DW-1:0] cpu_rd_data;

  modport master (
    output cpu_wr_req,
    output cpu_wr_addr,
    output cpu_wr_data,
    input  cpu_wr_ready,
    output cpu_rd_req,
    output cpu_rd_addr,
    input  cpu_rd_busy,
    input  cpu_rd_valid,
    input  cpu_rd_data
  );

  modport slave (
    input  cpu_wr_req,
    input  cpu_wr_addr,
    input  cpu_wr_data,
    output cpu_wr_ready,
    input  cpu_rd_req,
    input  cpu_rd_addr,
    output cpu_rd_busy,
    output cpu_rd_valid,
    output cpu_rd_data
  );
endinterface

// File: rtl/vram_port_arbiter_wr_fifo.sv
// Posted-write FIFO: registered storage, pointers carry a
// wrap bit so full/empty need no separate counter.
module vram_wr_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4
) (
  input  logic         vga_clk,
  input  logic         clrn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[IW] != rptr_q[IW]) &&
                 (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
  assign head  = mem_q[rptr_q[IW-1:0]];

  // A pop frees its slot before a same-cycle push lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage and pointers.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[IW-1:0]] = push_data;
      wptr_d = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  // Storage and pointer registers; reset discards contents.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port pixel RAM arbiter: VGA scan-out always wins,
// CPU writes drain and CPU reads complete only in blanking.
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                vga_clk,
  input  logic                clrn,
  input  logic                vga_rdn,
  input  logic [ROW_W-1:0]    vga_row,
  input  logic [COL_W-1:0]    vga_col,
  output logic [DW-1:0]       vga_data,
  vram_port_arbiter_if.slave  cpu,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_din,
  output logic                ram_we,
  input  logic [DW-1:0]       ram_dout
);
  logic [AW-1:0]    pix;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic [AW+DW-1:0] fifo_head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  logic             vga_sel, wr_sel, rd_sel;
  slot_e            slot;

  logic [1:0]       rd_state_q, rd_state_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;

  assign pix       = AW'(pix_addr(vga_row, vga_col));
  assign vga_data  = ram_dout;
  assign head_addr = fifo_head[AW+DW-1:DW];
  assign head_data = fifo_head[DW-1:0];

  // Ready reflects the pre-pop state, so a full FIFO
  // refuses a push even in a cycle that also drains.
  assign cpu.cpu_wr_ready = !fifo_full;
  assign fifo_push = cpu.cpu_wr_req && !fifo_full;
  assign fifo_pop  = (slot == SLOT_WR);

  vram_wr_fifo #(
    .W     (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .vga_clk   (vga_clk),
    .clrn      (clrn),
    .push      (fifo_push),
    .push_data ({cpu.cpu_wr_addr, cpu.cpu_wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Mutually exclusive slot qualifiers; reads wait for an
  // empty FIFO so they never overtake a posted write.
  assign vga_sel = !vga_rdn;
  assign wr_sel  = vga_rdn && !fifo_empty;
  assign rd_sel  = vga_rdn && fifo_empty &&
                   (rd_state_q == RD_PEND);

  // Slot decode for this cycle.
  always_comb begin
    slot = SLOT_NONE;
    unique case (1'b1)
      vga_sel: slot = SLOT_VGA;
      wr_sel:  slot = SLOT_WR;
      rd_sel:  slot = SLOT_RD;
      default: slot = SLOT_NONE;
    endcase
  end

  // RAM port mux driven by the granted slot.
  always_comb begin
    ram_addr = pix;
    ram_din  = head_data;
    ram_we   = 1'b0;
    unique case (slot)
      SLOT_WR: begin
        ram_addr = head_addr;
        ram_we   = 1'b1;
      end
      SLOT_RD: ram_addr = rd_addr_q;
      default: ram_addr = pix;
    endcase
  end

  // Read FSM: latch request, wait for a read slot, pulse.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (cpu.cpu_rd_req) begin
          rd_addr_d  = cpu.cpu_rd_addr;
          rd_state_d = RD_PEND;
        end
      end
      RD_PEND: begin
        if (slot == SLOT_RD) begin
          rd_data_d  = ram_dout;
          rd_state_d = RD_DONE;
        end
      end
      RD_DONE: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign cpu.cpu_rd_busy  = (rd_state_q != RD_IDLE);
  assign cpu.cpu_rd_valid = (rd_state_q == RD_DONE);
  assign cpu.cpu_rd_data  = rd_data_q;

  // Read FSM registers; reset drops any pending read.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed
// scenarios then random traffic against a queue model.
module tb_vram_port_arbiter;
  import vram_port_arbiter_pkg::*;

  localparam int AW    = 19;
  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic          vga_clk = 1'b0;
  logic          clrn    = 1'b0;
  logic          vga_rdn = 1'b0;
  logic [8:0]    vga_row = '0;
  logic [9:0]    vga_col = '0;
  logic [DW-1:0] vga_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  vram_port_arbiter_if #(.AW(AW), .DW(DW)) cpu ();

  vram_port_arbiter #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .vga_clk  (vga_clk),
    .clrn     (clrn),
    .vga_rdn  (vga_rdn),
    .vga_row  (vga_row),
    .vga_col  (vga_col),
    .vga_data (vga_data),
    .cpu      (cpu),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 vga_clk = ~vga_clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge vga_clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end
  assign ram_dout = mem[ram_addr];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            ph;
  logic [AW-1:0] rq_addr;
  logic [DW-1:0] exp_rd;
  int            n_assert;
  int            n_fail;
  int            valid_cnt;

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] e_addr;
    logic          e_we;
    e_addr = {vga_row, vga_col};
    e_we   = 1'b0;
    if (vga_rdn && q.size() > 0) begin
      e_addr = q[0].a;
      e_we   = 1'b1;
      chk("ram_din", 32'(ram_din), 32'(q[0].d));
    end else if (vga_rdn && ph == 1) begin
      e_addr = rq_addr;
    end
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("wr_ready", 32'(cpu.cpu_wr_ready),
        32'(q.size() < DEPTH));
    chk("rd_busy", 32'(cpu.cpu_rd_busy), 32'(ph != 0));
    chk("rd_valid", 32'(cpu.cpu_rd_valid), 32'(ph == 2));
    chk("rd_data", 32'(cpu.cpu_rd_data), 32'(exp_rd));
    if (!vga_rdn)
      chk("vga_data", 32'(vga_data), 32'(mem[e_addr]));
    if (cpu.cpu_rd_valid) valid_cnt++;
  endtask

  task automatic model_edge();
    bit svc, wacc, pop;
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (clrn) begin
      svc  = vga_rdn && q.size() == 0 && ph == 1;
      pop  = vga_rdn && q.size() > 0;
      wacc = cpu.cpu_wr_req && q.size() < DEPTH;
      if (ph == 2) ph = 0;
      else if (ph == 1) begin
        if (svc) begin
          exp_rd = ref_rd(rq_addr);
          ph = 2;
        end
      end else if (cpu.cpu_rd_req) begin
        rq_addr = cpu.cpu_rd_addr;
        ph = 1;
      end
      if (pop) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (wacc)
        q.push_back('{a: cpu.cpu_wr_addr, d: cpu.cpu_wr_data});
    end
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge vga_clk);
    model_edge();
    @(negedge vga_clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() > 0 || ph != 0); i++) begin
      settle();
      tick();
    end
  endtask

  initial begin
    bit hold;
    n_assert = 0; n_fail = 0; valid_cnt = 0;
    ph = 0; exp_rd = '0; rq_addr = '0;
    cpu.cpu_wr_req = 0; cpu.cpu_wr_addr = '0;
    cpu.cpu_wr_data = '0; cpu.cpu_rd_req = 0;
    cpu.cpu_rd_addr = '0;

    // reset with RAM preload
    @(negedge vga_clk);
    pl_en = 1; pl_addr = 19'h7FFFF; pl_data = 12'h123;
    settle();
    chk("rst_ready", 32'(cpu.cpu_wr_ready), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    tick();
    pl_addr = 19'h00200; pl_data = 12'h456;
    settle(); tick();
    pl_en = 0; clrn = 1;

    // VGA priority with 3 posted writes
    vga_rdn = 0; vga_row = 9'd5; vga_col = 10'd10;
    for (int i = 0; i < 3; i++) begin
      cpu.cpu_wr_req  = 1;
      cpu.cpu_wr_addr = 19'h00010 + 19'(i);
      cpu.cpu_wr_data = 12'h100 + 12'(i);
      settle();
      chk("vga_addr", 32'(ram_addr), 32'h0140A);
      chk("vga_we", 32'(ram_we), 32'd0);
      tick();
    end
    cpu.cpu_wr_req = 0;
    settle();
    chk("vga_addr_hold", 32'(ram_addr), 32'h0140A);
    tick();
    vga_rdn = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_we", 32'(ram_we), 32'd1);
      tick();
    end
    settle();
    chk("drain_done", 32'(ram_we), 32'd0);
    tick();

    // FIFO full during active video
    vga_rdn = 0;
    for (int i = 0; i < 5; i++) begin
      cpu.cpu_wr_req  = 1;
      cpu.cpu_wr_addr = 19'h00020 + 19'(i);
      cpu.cpu_wr_data = 12'h200 + 12'(i);
      settle(); tick();
    end
    settle();
    chk("full_ready", 32'(cpu.cpu_wr_ready), 32'd0);
    tick();
    vga_rdn = 1;
    settle();
    chk("full_prepop", 32'(cpu.cpu_wr_ready), 32'd0);
    tick();
    settle();
    chk("full_freed", 32'(cpu.cpu_wr_ready), 32'd1);
    tick();
    cpu.cpu_wr_req = 0;
    drain();

    // read-after-write in the same cycle
    cpu.cpu_wr_req = 1; cpu.cpu_wr_addr = 19'h00100;
    cpu.cpu_wr_data = 12'hABC;
    cpu.cpu_rd_req = 1; cpu.cpu_rd_addr = 19'h00100;
    settle(); tick();
    cpu.cpu_wr_req = 0; cpu.cpu_rd_req = 0;
    valid_cnt = 0;
    repeat (6) begin settle(); tick(); end
    chk("raw_pulses", 32'(valid_cnt), 32'd1);
    chk("raw_data", 32'(cpu.cpu_rd_data), 32'hABC);

    // blanking read latency
    cpu.cpu_rd_req = 1; cpu.cpu_rd_addr = 19'h7FFFF;
    settle(); tick();
    cpu.cpu_rd_req = 0;
    settle();
    chk("lat_n1_busy", 32'(cpu.cpu_rd_busy), 32'd1);
    chk("lat_n1_valid", 32'(cpu.cpu_rd_valid), 32'd0);
    chk("lat_n1_addr", 32'(ram_addr), 32'h7FFFF);
    tick();
    settle();
    chk("lat_n2_valid", 32'(cpu.cpu_rd_valid), 32'd1);
    chk("lat_n2_data", 32'(cpu.cpu_rd_data), 32'h123);
    tick();
    settle();
    chk("lat_n3_busy", 32'(cpu.cpu_rd_busy), 32'd0);
    tick();

    // second read while busy is ignored
    cpu.cpu_rd_req = 1; cpu.cpu_rd_addr = 19'h00200;
    valid_cnt = 0;
    settle(); tick();
    cpu.cpu_rd_addr = 19'h7FFFF;
    repeat (2) begin settle(); tick(); end
    cpu.cpu_rd_req = 0;
    repeat (3) begin settle(); tick(); end
    chk("busy_pulses", 32'(valid_cnt), 32'd1);
    chk("busy_data", 32'(cpu.cpu_rd_data), 32'h456);

    // reset mid-operation with writes and a read pending
    vga_rdn = 0;
    cpu.cpu_rd_req = 1; cpu.cpu_rd_addr = 19'h00001;
    cpu.cpu_wr_req = 1; cpu.cpu_wr_addr = 19'h00003;
    cpu.cpu_wr_data = 12'h777;
    settle(); tick();
    cpu.cpu_rd_req = 0; cpu.cpu_wr_addr = 19'h00004;
    settle(); tick();
    cpu.cpu_wr_req = 0;
    clrn = 0;
    q.delete(); ph = 0; exp_rd = '0;
    settle();
    chk("mid_rst_busy", 32'(cpu.cpu_rd_busy), 32'd0);
    chk("mid_rst_data", 32'(cpu.cpu_rd_data), 32'd0);
    tick();
    clrn = 1; vga_rdn = 1;
    settle();
    chk("post_rst_we", 32'(ram_we), 32'd0);
    chk("post_rst_ready", 32'(cpu.cpu_wr_ready), 32'd1);
    tick();

    // random traffic against the model
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      vga_rdn = ($urandom_range(0, 2) != 0);
      vga_row = 9'($urandom_range(0, 1));
      vga_col = 10'($urandom_range(0, 7));
      if (!hold) begin
        cpu.cpu_wr_req  = $urandom_range(0, 1) == 1;
        cpu.cpu_wr_addr = 19'($urandom_range(0, 7));
        cpu.cpu_wr_data = 12'($urandom);
      end
      cpu.cpu_rd_req  = $urandom_range(0, 3) == 0;
      cpu.cpu_rd_addr = 19'($urandom_range(0, 7));
      hold = cpu.cpu_wr_req && q.size() >= DEPTH;
      settle(); tick();
    end
    cpu.cpu_wr_req = 0; cpu.cpu_rd_req = 0; vga_rdn = 1;
    drain();
    settle();
    chk("end_busy", 32'(cpu.cpu_rd_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
